coded_lock_ctrl: RTL and testbench

Sequential controller for the keypad-entry coded lock. It collects a multi-digit code from a debounced keypad one digit at a time and compares it with a stored, reprogrammable code. It then drives the open and alarm indications, counting failed attempts, timing auto-relock and timing an alarm lockout. It sits between the keypad scanner/debouncer and the board top. Board top inverts open/alarm for the active-low LEDs.

---
 rtl/coded_lock_pkg.sv | 19 +
 rtl/lock_timer.sv | 28 ++
 rtl/coded_lock_ctrl.sv | 159 +++++++++++++++
 tb/tb_coded_lock_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coded_lock_pkg.sv
// rtl/coded_lock_pkg.sv - shared state encoding, default widths and code-width helper for the coded lock
package coded_lock_pkg;

    localparam int DEF_DIGIT_W  = 4;
    localparam int DEF_CODE_LEN = 4;

    typedef enum logic [2:0] {
        ST_LOCKED  = 3'd0,
        ST_CHECK   = 3'd1,
        ST_OPEN    = 3'd2,
        ST_PROG    = 3'd3,
        ST_LOCKOUT = 3'd4
    } lock_state_e;

    function automatic int code_width(input int code_len, input int digit_w);
        return code_len * digit_w;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// rtl/lock_timer.sv - up-counter with synchronous clear, enable and terminal count against a runtime limit
module lock_timer #(
    parameter int CNT_W = 27
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             tc
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    // Terminal count marks the last cycle of the window, so the owner leaves on this edge.
    assign tc = (count == limit - CNT_W'(1));

endmodule

// File: rtl/coded_lock_ctrl.sv
// rtl/coded_lock_ctrl.sv - keypad code entry, compare, auto-relock, reprogramming and alarm lockout controller
module coded_lock_ctrl
    import coded_lock_pkg::*;
#(
    parameter int          CODE_LEN       = DEF_CODE_LEN,
    parameter int          DIGIT_W        = DEF_DIGIT_W,
    parameter logic [code_width(CODE_LEN, DIGIT_W)-1:0] DEFAULT_CODE = 16'h1234,
    parameter int          MAX_TRIES      = 3,
    parameter int unsigned OPEN_CYCLES    = 12_000_000,
    parameter int unsigned LOCKOUT_CYCLES = 120_000_000,
    parameter int          CNT_W          = 27
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_vld,
    input  logic [DIGIT_W-1:0] key_val,
    input  logic               key_clr,
    input  logic               lock_req,
    input  logic               prog_req,
    output logic               open,
    output logic               alarm,
    output logic [2:0]         state_o,
    output logic [2:0]         err_cnt
);

    localparam int CW  = code_width(CODE_LEN, DIGIT_W);
    localparam int DCW = $clog2(CODE_LEN + 1);

    lock_state_e      state, state_n;
    logic [CW-1:0]    entry, entry_n;
    logic [CW-1:0]    code, code_n;
    logic [CW-1:0]    shifted;
    logic [DCW-1:0]   dcnt, dcnt_n;
    logic [2:0]       err, err_n;
    logic             last_digit;
    logic             tmr_clr, tmr_en, tmr_tc;
    logic [CNT_W-1:0] tmr_limit;

    assign shifted    = {entry[CW-DIGIT_W-1:0], key_val};
    assign last_digit = (dcnt == DCW'(CODE_LEN - 1));
    assign tmr_limit  = (state == ST_LOCKOUT) ? CNT_W'(LOCKOUT_CYCLES) : CNT_W'(OPEN_CYCLES);

    lock_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .limit (tmr_limit),
        .tc    (tmr_tc)
    );

    always_comb begin
        state_n = state;
        entry_n = entry;
        dcnt_n  = dcnt;
        code_n  = code;
        err_n   = err;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;
        unique case (state)
            ST_LOCKED: begin
                if (key_clr) begin
                    entry_n = '0;
                    dcnt_n  = '0;
                end else if (key_vld) begin
                    entry_n = shifted;
                    dcnt_n  = dcnt + DCW'(1);
                    if (last_digit) state_n = ST_CHECK;
                end
            end
            ST_CHECK: begin
                entry_n = '0;
                dcnt_n  = '0;
                if (entry == code) begin
                    state_n = ST_OPEN;
                    err_n   = '0;
                    tmr_clr = 1'b1;
                end else if (err + 3'd1 == 3'(MAX_TRIES)) begin
                    state_n = ST_LOCKOUT;
                    err_n   = 3'(MAX_TRIES);
                    tmr_clr = 1'b1;
                end else begin
                    state_n = ST_LOCKED;
                    err_n   = err + 3'd1;
                end
            end
            ST_OPEN: begin
                tmr_en = 1'b1;
                if (lock_req || (!prog_req && tmr_tc)) begin
                    state_n = ST_LOCKED;
                    entry_n = '0;
                    dcnt_n  = '0;
                end else if (prog_req) begin
                    state_n = ST_PROG;
                    entry_n = '0;
                    dcnt_n  = '0;
                end
            end
            ST_PROG: begin
                // lock_req outranks everything so a half-typed new code is never committed.
                if (lock_req) begin
                    state_n = ST_LOCKED;
                    entry_n = '0;
                    dcnt_n  = '0;
                end else if (key_clr) begin
                    state_n = ST_OPEN;
                    tmr_clr = 1'b1;
                end else if (key_vld) begin
                    entry_n = shifted;
                    dcnt_n  = dcnt + DCW'(1);
                    if (last_digit) begin
                        code_n  = shifted;
                        state_n = ST_OPEN;
                        tmr_clr = 1'b1;
                    end
                end
            end
            ST_LOCKOUT: begin
                tmr_en = 1'b1;
                if (tmr_tc) begin
                    state_n = ST_LOCKED;
                    err_n   = '0;
                    entry_n = '0;
                    dcnt_n  = '0;
                end
            end
            default: begin
                state_n = ST_LOCKED;
                entry_n = '0;
                dcnt_n  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_LOCKED;
            entry <= '0;
            dcnt  <= '0;
            code  <= DEFAULT_CODE;
            err   <= '0;
            open  <= 1'b0;
            alarm <= 1'b0;
        end else begin
            state <= state_n;
            entry <= entry_n;
            dcnt  <= dcnt_n;
            code  <= code_n;
            err   <= err_n;
            // Indications follow the next state so they are registered yet aligned with it.
            open  <= (state_n == ST_OPEN) || (state_n == ST_PROG);
            alarm <= (state_n == ST_LOCKOUT);
        end
    end

    assign state_o = state;
    assign err_cnt = err;

endmodule

// File: tb/tb_coded_lock_ctrl.sv
// tb/tb_coded_lock_ctrl.sv - randomized self-checking bench for coded_lock_ctrl against a transaction-level lock model
module tb_coded_lock_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_vld = 1'b0;
    logic [3:0] key_val = 4'h0;
    logic       key_clr = 1'b0;
    logic       lock_req = 1'b0;
    logic       prog_req = 1'b0;
    logic       open, alarm;
    logic [2:0] state_o, err_cnt;

    int total = 0;
    int bad = 0;

    logic [15:0] model_code = 16'h1234;
    int          model_err  = 0;

    coded_lock_ctrl #(
        .CODE_LEN(4), .DIGIT_W(4), .DEFAULT_CODE(16'h1234), .MAX_TRIES(3),
        .OPEN_CYCLES(16), .LOCKOUT_CYCLES(32), .CNT_W(27)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_vld(key_vld), .key_val(key_val),
        .key_clr(key_clr), .lock_req(lock_req), .prog_req(prog_req),
        .open(open), .alarm(alarm), .state_o(state_o), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        key_val = d;
        key_vld = 1'b1;
        tick();
        key_vld = 1'b0;
        key_val = 4'($urandom);
    endtask

    task automatic enter_code(input logic [15:0] c);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) repeat ($urandom_range(0, 2)) tick();
            press(c[15-4*i -: 4]);
        end
    endtask

    task automatic pulse_lock();
        lock_req = 1'b1;
        tick();
        lock_req = 1'b0;
    endtask

    task automatic pulse_prog();
        prog_req = 1'b1;
        tick();
        prog_req = 1'b0;
    endtask

    task automatic count_high(input bit use_alarm, output int n);
        n = 0;
        while ((use_alarm ? alarm : open) === 1'b1 && n < 200) begin
            n++;
            tick();
        end
    endtask

    function automatic logic [15:0] wrong_code();
        logic [15:0] w;
        w = 16'($urandom);
        if (w == model_code) w = ~w;
        return w;
    endfunction

    task automatic test_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        total++; if (state_o !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state_o); end
        total++; if (open !== 1'b0 || alarm !== 1'b0) begin bad++; $display("FAIL reset_outs got=%b%b want=00", open, alarm); end
        total++; if (err_cnt !== 3'd0) begin bad++; $display("FAIL reset_err got=%0d want=0", err_cnt); end
        pulse_lock();
        pulse_prog();
        total++; if (state_o !== 3'd0 || open !== 1'b0) begin bad++; $display("FAIL locked_ignores_req got=%0d/%b want=0/0", state_o, open); end
    endtask

    task automatic test_correct();
        int n;
        enter_code(model_code);
        total++; if (state_o !== 3'd1) begin bad++; $display("FAIL correct_check got=%0d want=1", state_o); end
        total++; if (open !== 1'b0) begin bad++; $display("FAIL correct_latency got=%b want=0", open); end
        tick();
        total++; if (open !== 1'b1 || alarm !== 1'b0 || state_o !== 3'd2) begin bad++; $display("FAIL correct_open got=%b%b/%0d want=10/2", open, alarm, state_o); end
        count_high(1'b0, n);
        total++; if (n !== 16) begin bad++; $display("FAIL open_duration got=%0d want=16", n); end
        total++; if (state_o !== 3'd0) begin bad++; $display("FAIL relock_state got=%0d want=0", state_o); end
    endtask

    task automatic test_wrong_lockout();
        int n;
        bit both;
        for (int k = 1; k <= 3; k++) begin
            enter_code(wrong_code());
            tick();
            model_err++;
            if (k < 3) begin
                total++; if (err_cnt !== 3'(k) || open !== 1'b0 || alarm !== 1'b0) begin bad++; $display("FAIL wrong_try%0d got=err%0d/%b%b want=err%0d/00", k, err_cnt, open, alarm, k); end
            end else begin
                total++; if (alarm !== 1'b1 || open !== 1'b0 || err_cnt !== 3'd3 || state_o !== 3'd4) begin bad++; $display("FAIL lockout_enter got=%b%b/err%0d/st%0d want=01/err3/st4", open, alarm, err_cnt, state_o); end
            end
        end
        n = 0;
        both = 1'b0;
        while (alarm === 1'b1 && n < 200) begin
            key_vld  = 1'($urandom);
            key_val  = 4'($urandom);
            key_clr  = 1'($urandom);
            lock_req = 1'($urandom);
            prog_req = 1'($urandom);
            if (open === 1'b1) both = 1'b1;
            n++;
            tick();
        end
        {key_vld, key_clr, lock_req, prog_req} = 4'b0;
        total++; if (n !== 32) begin bad++; $display("FAIL lockout_duration got=%0d want=32", n); end
        total++; if (both !== 1'b0) begin bad++; $display("FAIL lockout_exclusive got=%b want=0", both); end
        total++; if (err_cnt !== 3'd0 || state_o !== 3'd0 || open !== 1'b0) begin bad++; $display("FAIL lockout_exit got=err%0d/st%0d/%b want=err0/st0/0", err_cnt, state_o, open); end
        model_err = 0;
        enter_code(model_code);
        tick();
        total++; if (open !== 1'b1) begin bad++; $display("FAIL post_lockout_open got=%b want=1", open); end
        pulse_lock();
        total++; if (open !== 1'b0 || state_o !== 3'd0) begin bad++; $display("FAIL lock_req got=%b/%0d want=0/0", open, state_o); end
    endtask

    task automatic test_clear();
        press(4'h1);
        press(4'h2);
        key_clr = 1'b1; key_vld = 1'b1; key_val = 4'h9;
        tick();
        key_clr = 1'b0; key_vld = 1'b0;
        enter_code(model_code);
        tick();
        total++; if (open !== 1'b1) begin bad++; $display("FAIL clear_then_open got=%b want=1", open); end
        pulse_lock();
        press(4'h1);
        press(4'h2);
        key_clr = 1'b1; key_vld = 1'b1; key_val = 4'h9;
        tick();
        key_clr = 1'b0; key_vld = 1'b0;
        enter_code(16'h1291);
        total++; if (state_o !== 3'd1) begin bad++; $display("FAIL clear_restart got=%0d want=1", state_o); end
        tick();
        model_err++;
        total++; if (open !== 1'b0 || err_cnt !== 3'(model_err)) begin bad++; $display("FAIL clear_wrong got=%b/err%0d want=0/err%0d", open, err_cnt, model_err); end
        enter_code(model_code);
        tick();
        model_err = 0;
        total++; if (open !== 1'b1 || err_cnt !== 3'd0) begin bad++; $display("FAIL clear_err_reset got=%b/err%0d want=1/err0", open, err_cnt); end
        pulse_lock();
    endtask

    task automatic test_random_attempts();
        logic [15:0] c;
        bit exp_open;
        int n;
        for (int it = 0; it < 10; it++) begin
            c = ($urandom_range(0, 1) == 1) ? model_code : 16'($urandom);
            enter_code(c);
            total++; if (state_o !== 3'd1) begin bad++; $display("FAIL rnd_check it%0d got=%0d want=1", it, state_o); end
            tick();
            exp_open = (c == model_code);
            model_err = exp_open ? 0 : model_err + 1;
            total++; if (open !== exp_open || alarm !== (model_err == 3) || err_cnt !== 3'(model_err)) begin
                bad++; $display("FAIL rnd_result it%0d code=%h got=%b%b/err%0d want=%b%b/err%0d", it, c, open, alarm, err_cnt, exp_open, model_err == 3, model_err);
            end
            if (open === 1'b1) pulse_lock();
            if (alarm === 1'b1) begin
                count_high(1'b1, n);
                model_err = 0;
                total++; if (n !== 32 || err_cnt !== 3'd0) begin bad++; $display("FAIL rnd_lockout it%0d got=%0d/err%0d want=32/err0", it, n, err_cnt); end
            end
        end
    endtask

    task automatic test_prog();
        logic [15:0] nc;
        int n;
        nc = 16'hABCD;
        enter_code(model_code);
        tick();
        pulse_prog();
        total++; if (state_o !== 3'd3 || open !== 1'b1) begin bad++; $display("FAIL prog_enter got=%0d/%b want=3/1", state_o, open); end
        for (int i = 0; i < 4; i++) begin
            press(nc[15-4*i -: 4]);
            if (i < 3) begin
                total++; if (state_o !== 3'd3 || open !== 1'b1) begin bad++; $display("FAIL prog_digit%0d got=%0d/%b want=3/1", i, state_o, open); end
            end
        end
        total++; if (state_o !== 3'd2 || open !== 1'b1) begin bad++; $display("FAIL prog_done got=%0d/%b want=2/1", state_o, open); end
        model_code = nc;
        count_high(1'b0, n);
        total++; if (n !== 16) begin bad++; $display("FAIL prog_timer_restart got=%0d want=16", n); end
        enter_code(16'h1234);
        tick();
        model_err++;
        total++; if (open !== 1'b0 || err_cnt !== 3'(model_err)) begin bad++; $display("FAIL old_code_rejected got=%b/err%0d want=0/err%0d", open, err_cnt, model_err); end
        enter_code(model_code);
        tick();
        model_err = 0;
        total++; if (open !== 1'b1) begin bad++; $display("FAIL new_code_opens got=%b want=1", open); end
        pulse_lock();
    endtask

    task automatic test_prog_abort();
        logic [15:0] x;
        int n;
        enter_code(model_code);
        tick();
        pulse_prog();
        press(4'($urandom));
        press(4'($urandom));
        key_clr = 1'b1;
        tick();
        key_clr = 1'b0;
        total++; if (state_o !== 3'd2 || open !== 1'b1) begin bad++; $display("FAIL prog_clr_abort got=%0d/%b want=2/1", state_o, open); end
        count_high(1'b0, n);
        total++; if (n !== 16) begin bad++; $display("FAIL prog_clr_timer got=%0d want=16", n); end
        enter_code(model_code);
        tick();
        total++; if (open !== 1'b1) begin bad++; $display("FAIL code_kept_clr got=%b want=1", open); end
        pulse_prog();
        press(4'($urandom));
        pulse_lock();
        total++; if (state_o !== 3'd0 || open !== 1'b0) begin bad++; $display("FAIL prog_lock_abort got=%0d/%b want=0/0", state_o, open); end
        enter_code(model_code);
        tick();
        total++; if (open !== 1'b1) begin bad++; $display("FAIL code_kept_lock got=%b want=1", open); end
        x = wrong_code();
        pulse_prog();
        for (int i = 0; i < 3; i++) press(x[15-4*i -: 4]);
        key_vld = 1'b1; key_val = x[3:0]; lock_req = 1'b1;
        tick();
        key_vld = 1'b0; lock_req = 1'b0;
        total++; if (state_o !== 3'd0 || open !== 1'b0) begin bad++; $display("FAIL lock_beats_digit got=%0d/%b want=0/0", state_o, open); end
        enter_code(model_code);
        tick();
        total++; if (open !== 1'b1) begin bad++; $display("FAIL code_kept_final got=%b want=1", open); end
        pulse_lock();
    endtask

    task automatic test_reset_mid();
        logic [15:0] nc;
        nc = 16'($urandom);
        if (nc == 16'h1234) nc = 16'h5678;
        enter_code(model_code);
        tick();
        pulse_prog();
        enter_code(nc);
        @(posedge clk);
        #4;
        rst_n = 1'b0;
        #1;
        total++; if (open !== 1'b0 || alarm !== 1'b0 || state_o !== 3'd0) begin bad++; $display("FAIL async_reset got=%b%b/%0d want=00/0", open, alarm, state_o); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_code = 16'h1234;
        model_err = 0;
        enter_code(nc);
        tick();
        model_err++;
        total++; if (open !== 1'b0 || err_cnt !== 3'd1) begin bad++; $display("FAIL reset_reverts_code got=%b/err%0d want=0/err1", open, err_cnt); end
        enter_code(16'h1234);
        tick();
        model_err = 0;
        total++; if (open !== 1'b1) begin bad++; $display("FAIL default_after_reset got=%b want=1", open); end
        pulse_lock();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_correct();
        test_wrong_lockout();
        test_clear();
        test_random_attempts();
        test_prog();
        test_prog_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
